// File: rtl/sfr_arb.sv
// sfr_arb: two-port (A/B) arbiter onto a single-cycle SFR register-file bus with lock and round-robin/fixed priority
module sfr_arb #(
  parameter bit PRIO_FIX = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       a_req,
  input  logic       b_req,
  input  logic       a_lock,
  input  logic       b_lock,
  input  logic       a_we,
  input  logic       b_we,
  input  logic [5:0] a_addr,
  input  logic [5:0] b_addr,
  input  logic [7:0] a_wdata,
  input  logic [7:0] b_wdata,
  output logic       a_gnt,
  output logic       b_gnt,
  output logic [7:0] a_rdata,
  output logic [7:0] b_rdata,
  output logic       a_rvld,
  output logic       b_rvld,
  input  logic [7:0] sfr_rdata,
  output logic [5:0] sfr_addrs,
  output logic [7:0] sfr_wdata,
  output logic       sfr_wctrl,
  output logic       sfr_rctrl,
  output logic       busy
);
  typedef enum logic {IDLE, ACC} state_t;
  state_t state, nxt;
  logic cur, l_we, own_v, own, last, held, w_v, w, rd_a, rd_b;
  logic [5:0] l_addr;
  logic [7:0] l_wdata;
  always_comb begin
    held = own_v && (own ? b_lock : a_lock);
    w_v  = held ? (own ? b_req : a_req) : (a_req | b_req);
    w    = held ? own : (a_req && b_req) ? (PRIO_FIX ? 1'b0 : ~last) : b_req;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nxt;
  always_comb nxt = w_v ? ACC : IDLE;
  always_comb begin
    busy      = state == ACC;
    a_gnt     = busy && !cur;
    b_gnt     = busy && cur;
    sfr_wctrl = busy && l_we;
    sfr_rctrl = busy && !l_we;
    sfr_addrs = busy ? l_addr : 6'd0;
    sfr_wdata = busy ? l_wdata : 8'd0;
    rd_a      = sfr_rctrl && !cur;
    rd_b      = sfr_rctrl && cur;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cur     <= 1'b0;
      l_we    <= 1'b0;
      l_addr  <= 6'd0;
      l_wdata <= 8'd0;
      own_v   <= 1'b0;
      own     <= 1'b0;
      last    <= 1'b1;
      a_rdata <= 8'd0;
      b_rdata <= 8'd0;
      a_rvld  <= 1'b0;
      b_rvld  <= 1'b0;
    end else begin
      a_rvld <= rd_a;
      b_rvld <= rd_b;
      if (rd_a) a_rdata <= sfr_rdata;
      if (rd_b) b_rdata <= sfr_rdata;
      if (w_v) begin
        cur     <= w;
        l_we    <= w ? b_we : a_we;
        l_addr  <= w ? b_addr : a_addr;
        l_wdata <= w ? b_wdata : a_wdata;
        last    <= w;
      end
      if (w_v && (w ? b_lock : a_lock)) begin
        own_v <= 1'b1;
        own   <= w;
      end else if (!held) own_v <= 1'b0;
    end
endmodule

// File: tb/tb_sfr_arb.sv
// tb_sfr_arb: drives a round-robin and a fixed-priority sfr_arb in parallel, directed scenarios plus random traffic vs a transaction model
module tb_sfr_arb;
  logic clk = 1'b0, rst = 1'b0;
  logic a_req = 1'b0, b_req = 1'b0, a_lock = 1'b0, b_lock = 1'b0, a_we = 1'b0, b_we = 1'b0;
  logic [5:0] a_addr = 6'd0, b_addr = 6'd0;
  logic [7:0] a_wdata = 8'd0, b_wdata = 8'd0;
  logic busy [2], a_gnt [2], b_gnt [2], a_rvld [2], b_rvld [2], sfr_wctrl [2], sfr_rctrl [2];
  logic [7:0] a_rdata [2], b_rdata [2], sfr_rdata [2], sfr_wdata [2];
  logic [5:0] sfr_addrs [2];
  logic [36:0] obs [2];
  logic [7:0] mem [2][64];
  int npass = 0, ntot = 0;
  // transaction model: pending access, lock owner, last served, read results
  bit cv [2], cwe [2], ov [2];
  int cp [2], ow [2], ls [2];
  logic [5:0] caddr [2];
  logic [7:0] cwd [2], mm [2][64], rd [2][2];
  bit rv [2][2];
  always #5 clk = ~clk;
  for (genvar g = 0; g < 2; g++) begin : gen_dut
    sfr_arb #(.PRIO_FIX(g == 1)) u_dut (
      .clk(clk), .rst(rst),
      .a_req(a_req), .b_req(b_req), .a_lock(a_lock), .b_lock(b_lock),
      .a_we(a_we), .b_we(b_we), .a_addr(a_addr), .b_addr(b_addr),
      .a_wdata(a_wdata), .b_wdata(b_wdata),
      .a_gnt(a_gnt[g]), .b_gnt(b_gnt[g]), .a_rdata(a_rdata[g]), .b_rdata(b_rdata[g]),
      .a_rvld(a_rvld[g]), .b_rvld(b_rvld[g]), .sfr_rdata(sfr_rdata[g]),
      .sfr_addrs(sfr_addrs[g]), .sfr_wdata(sfr_wdata[g]),
      .sfr_wctrl(sfr_wctrl[g]), .sfr_rctrl(sfr_rctrl[g]), .busy(busy[g])
    );
    assign sfr_rdata[g] = mem[g][sfr_addrs[g]];
    assign obs[g] = {busy[g], a_gnt[g], b_gnt[g], sfr_wctrl[g], sfr_rctrl[g], a_rvld[g], b_rvld[g],
                     sfr_addrs[g], sfr_wdata[g], a_rdata[g], b_rdata[g]};
  end
  always @(posedge clk)
    for (int i = 0; i < 2; i++)
      if (sfr_wctrl[i]) mem[i][sfr_addrs[i]] <= sfr_wdata[i];
  function automatic logic [36:0] expv(input int g);
    logic v;
    v = cv[g];
    return {v, v && cp[g] == 0, v && cp[g] == 1, v && cwe[g], v && !cwe[g], rv[g][0], rv[g][1],
            v ? caddr[g] : 6'd0, v ? cwd[g] : 8'd0, rd[g][0], rd[g][1]};
  endfunction
  task automatic model_step(input int g);
    logic [1:0] rq, lk;
    int win;
    bit hold;
    rq = {b_req, a_req};
    lk = {b_lock, a_lock};
    rv[g][0] = 0;
    rv[g][1] = 0;
    if (cv[g]) begin
      if (cwe[g]) mm[g][caddr[g]] = cwd[g];
      else begin
        rd[g][cp[g]] = mm[g][caddr[g]];
        rv[g][cp[g]] = 1;
      end
    end
    hold = ov[g] && lk[ow[g]];
    win = -1;
    if (hold) begin
      if (rq[ow[g]]) win = ow[g];
    end else if (rq == 2'b11) win = (g == 1) ? 0 : 1 - ls[g];
    else if (rq != 2'b00) win = rq[1] ? 1 : 0;
    cv[g] = win >= 0;
    if (win >= 0) begin
      cp[g] = win;
      cwe[g] = (win == 1) ? b_we : a_we;
      caddr[g] = (win == 1) ? b_addr : a_addr;
      cwd[g] = (win == 1) ? b_wdata : a_wdata;
      ls[g] = win;
    end
    if (win >= 0 && lk[win]) begin
      ov[g] = 1;
      ow[g] = win;
    end else if (!hold) ov[g] = 0;
  endtask
  task automatic do_reset();
    {a_req, b_req, a_lock, b_lock, a_we, b_we} = '0;
    a_addr = 6'd0; b_addr = 6'd0; a_wdata = 8'd0; b_wdata = 8'd0;
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask
  task automatic test_reset();
    rst = 1'b0;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      ntot++;
      if (obs[g] !== 37'd0) $display("FAIL reset_outputs g=%0d got %h exp 0", g, obs[g]);
      else npass++;
    end
  endtask
  task automatic test_write_read();
    do_reset();
    a_req = 1; a_we = 1; a_addr = 6'h05; a_wdata = 8'hA5;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      ntot++;
      if ({sfr_wctrl[g], sfr_rctrl[g], a_gnt[g], b_gnt[g], sfr_addrs[g], sfr_wdata[g]} !== {4'b1010, 6'h05, 8'hA5})
        $display("FAIL write_access g=%0d got %b%b%b%b %h %h exp 1010 05 a5", g,
                 sfr_wctrl[g], sfr_rctrl[g], a_gnt[g], b_gnt[g], sfr_addrs[g], sfr_wdata[g]);
      else npass++;
    end
    a_we = 0; a_wdata = 8'd0;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      ntot++;
      if ({sfr_wctrl[g], sfr_rctrl[g], a_gnt[g], b_gnt[g], sfr_addrs[g]} !== {4'b0110, 6'h05})
        $display("FAIL read_access g=%0d got %b%b%b%b %h exp 0110 05", g,
                 sfr_wctrl[g], sfr_rctrl[g], a_gnt[g], b_gnt[g], sfr_addrs[g]);
      else npass++;
    end
    a_req = 0;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      ntot++;
      if ({busy[g], a_rvld[g], b_rvld[g], a_rdata[g]} !== {3'b010, 8'hA5})
        $display("FAIL read_data g=%0d got %b%b%b %h exp 010 a5", g, busy[g], a_rvld[g], b_rvld[g], a_rdata[g]);
      else npass++;
    end
  endtask
  task automatic test_conflict();
    logic [2:0] e;
    do_reset();
    a_req = 1; b_req = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        e = (g == 0 && i % 2 == 1) ? 3'b101 : 3'b110;
        ntot++;
        if ({busy[g], a_gnt[g], b_gnt[g]} !== e)
          $display("FAIL conflict_grant g=%0d i=%0d got %b%b%b exp %b", g, i, busy[g], a_gnt[g], b_gnt[g], e);
        else npass++;
      end
    end
    a_req = 0;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      ntot++;
      if ({busy[g], a_gnt[g], b_gnt[g]} !== 3'b101)
        $display("FAIL b_after_a_drop g=%0d got %b%b%b exp 101", g, busy[g], a_gnt[g], b_gnt[g]);
      else npass++;
    end
    b_req = 0;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      ntot++;
      if (busy[g] !== 1'b0) $display("FAIL idle_after_conflict g=%0d got %b exp 0", g, busy[g]);
      else npass++;
    end
  endtask
  task automatic test_lock();
    bit seen [2];
    do_reset();
    b_req = 1; b_lock = 1;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      ntot++;
      if (b_gnt[g] !== 1'b1) $display("FAIL lock_first_grant g=%0d got %b exp 1", g, b_gnt[g]);
      else npass++;
    end
    a_req = 1;
    for (int k = 0; k < 6; k++) begin
      b_req = (k % 2 == 0);
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        ntot++;
        if ({a_gnt[g], b_gnt[g]} !== {1'b0, k % 2 == 0})
          $display("FAIL lock_hold g=%0d k=%0d got a=%b b=%b exp a=0 b=%b", g, k, a_gnt[g], b_gnt[g], k % 2 == 0);
        else npass++;
      end
    end
    b_req = 0; b_lock = 0;
    seen[0] = 0; seen[1] = 0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      for (int g = 0; g < 2; g++) if (a_gnt[g]) seen[g] = 1;
    end
    for (int g = 0; g < 2; g++) begin
      ntot++;
      if (seen[g] !== 1'b1) $display("FAIL lock_release g=%0d a_gnt seen=%b exp 1 within 2 cycles", g, seen[g]);
      else npass++;
    end
    a_req = 0;
    @(negedge clk);
  endtask
  task automatic test_reset_mid();
    do_reset();
    b_req = 1; b_we = 0; b_addr = 6'h3F;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      ntot++;
      if ({sfr_rctrl[g], b_gnt[g], sfr_addrs[g]} !== {2'b11, 6'h3F})
        $display("FAIL mid_read_access g=%0d got %b%b %h exp 11 3f", g, sfr_rctrl[g], b_gnt[g], sfr_addrs[g]);
      else npass++;
    end
    b_req = 0; rst = 0;
    #1;
    for (int g = 0; g < 2; g++) begin
      ntot++;
      if (obs[g] !== 37'd0) $display("FAIL mid_reset_async g=%0d got %h exp 0", g, obs[g]);
      else npass++;
    end
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      ntot++;
      if (obs[g] !== 37'd0) $display("FAIL mid_reset_held g=%0d got %h exp 0", g, obs[g]);
      else npass++;
    end
    rst = 1; a_req = 1; b_req = 1;
    @(negedge clk);
    for (int g = 0; g < 2; g++) begin
      ntot++;
      if ({a_gnt[g], b_gnt[g], b_rvld[g]} !== 3'b100)
        $display("FAIL post_reset_conflict g=%0d got a=%b b=%b rvld=%b exp 100", g, a_gnt[g], b_gnt[g], b_rvld[g]);
      else npass++;
    end
    a_req = 0; b_req = 0;
    @(negedge clk);
  endtask
  task automatic test_random();
    do_reset();
    for (int g = 0; g < 2; g++) begin
      cv[g] = 0; ov[g] = 0; ow[g] = 0; ls[g] = 1; cp[g] = 0; cwe[g] = 0; caddr[g] = 0; cwd[g] = 0;
      rd[g][0] = 0; rd[g][1] = 0; rv[g][0] = 0; rv[g][1] = 0;
      for (int i = 0; i < 64; i++) mm[g][i] = mem[g][i];
    end
    for (int c = 0; c < 400; c++) begin
      a_req = $urandom_range(0, 9) < 6;
      b_req = $urandom_range(0, 9) < 6;
      a_lock = $urandom_range(0, 9) < 2;
      b_lock = $urandom_range(0, 9) < 2;
      a_we = 1'($urandom_range(0, 1));
      b_we = 1'($urandom_range(0, 1));
      a_addr = 6'($urandom);
      b_addr = 6'($urandom);
      a_wdata = 8'($urandom);
      b_wdata = 8'($urandom);
      for (int g = 0; g < 2; g++) model_step(g);
      @(negedge clk);
      for (int g = 0; g < 2; g++) begin
        ntot++;
        if (obs[g] !== expv(g)) $display("FAIL random c=%0d g=%0d got %h exp %h", c, g, obs[g], expv(g));
        else npass++;
      end
    end
    do_reset();
  endtask
  initial begin
    test_reset();
    test_write_read();
    test_conflict();
    test_lock();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end
endmodule
